// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 16-bit alu among NREQ valid/ready requesters; one op every 3 cycles.
// Optional ALU_ARB_ERR_EN adds rsp_err flagging the unused function code 3'b011.

module alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           sub_ovf;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    y         = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    // carry_out on SUB/SLT is the unsigned borrow (a < b)
    case (f)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: begin
        y         = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
        overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b100: y = a ^ b;
      3'b101: y = ~(a | b);
      3'b110: begin
        y         = diff[WIDTH-1:0];
        carry_out = diff[WIDTH];
        overflow  = sub_ovf;
      end
      3'b111: begin
        y         = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
        carry_out = diff[WIDTH];
      end
      default: y = '0;
    endcase
    zero = (y == '0);
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_f,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_zero,
  output logic                  rsp_carry,
  output logic                  rsp_ovf
`ifdef ALU_ARB_ERR_EN
  ,
  output logic                  rsp_err
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [2:0]       f_reg;
  logic             rsp_valid_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic [WIDTH-1:0] rsp_y_reg;
  logic             rsp_zero_reg, rsp_carry_reg, rsp_ovf_reg;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [2:0]       f_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    assign f_arr[gi] = req_f[gi*3 +: 3];
  end

  // Rotating priority search starting at rr_ptr, wrapping below NREQ
  logic           found;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] idx_w;
  int             idx;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (!found && req_valid[idx_w]) begin
        found = 1'b1;
        grant = idx_w;
      end
    end
  end

  logic accept;
  logic rsp_fire;
  logic [IDW-1:0] rr_next;

  assign accept   = (state_reg == IDLE) && found;
  assign rsp_fire = (state_reg == RESP) && rsp_ready;
  assign rr_next  = (id_reg == IDW'(NREQ-1)) ? '0 : id_reg + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  logic [WIDTH-1:0] alu_y;
  logic             alu_zero, alu_carry, alu_ovf;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a         (a_reg),
    .b         (b_reg),
    .f         (f_reg),
    .y         (alu_y),
    .zero      (alu_zero),
    .carry_out (alu_carry),
    .overflow  (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg    <= '0;
      id_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      f_reg         <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_y_reg     <= '0;
      rsp_zero_reg  <= 1'b0;
      rsp_carry_reg <= 1'b0;
      rsp_ovf_reg   <= 1'b0;
    end else begin
      if (accept) begin
        a_reg  <= a_arr[grant];
        b_reg  <= b_arr[grant];
        f_reg  <= f_arr[grant];
        id_reg <= grant;
      end
      if (state_reg == EXEC) begin
        rsp_valid_reg <= 1'b1;
        rsp_id_reg    <= id_reg;
        rsp_y_reg     <= alu_y;
        rsp_zero_reg  <= alu_zero;
        rsp_carry_reg <= alu_carry;
        rsp_ovf_reg   <= alu_ovf;
      end
      if (rsp_fire) begin
        rsp_valid_reg <= 1'b0;
        rr_ptr_reg    <= rr_next;
      end
    end
  end

`ifdef ALU_ARB_ERR_EN
  logic rsp_err_reg;

  always_ff @(posedge clk) begin
    if (reset)                   rsp_err_reg <= 1'b0;
    else if (state_reg == EXEC)  rsp_err_reg <= (f_reg == 3'b011);
  end

  assign rsp_err = rsp_err_reg;
`endif

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_y     = rsp_y_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign rsp_carry = rsp_carry_reg;
  assign rsp_ovf   = rsp_ovf_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed arbitration/stall/reset sequences, random scoreboard.
module tb_alu_arbiter;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ*3-1:0] req_f;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [WIDTH-1:0]  rsp_y;
  logic              rsp_zero, rsp_carry, rsp_ovf;
`ifdef ALU_ARB_ERR_EN
  logic              rsp_err;
`endif

  logic [15:0] va [NREQ];
  logic [15:0] vb [NREQ];
  logic [2:0]  vf [NREQ];

  always_comb begin
    req_a = '0;
    req_b = '0;
    req_f = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = va[i];
      req_b[i*WIDTH +: WIDTH] = vb[i];
      req_f[i*3 +: 3]         = vf[i];
    end
  end

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_f     (req_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf)
`ifdef ALU_ARB_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  f;
    logic [15:0] y;
    logic        z;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] y;
    logic        z;
    logic        c;
    logic        o;
  } res_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference ALU from plain integer arithmetic on the operand values
  function automatic res_t ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
    res_t r;
    int ua, ub, sa, sb, s, ss;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r.id = '0;
    r.y = '0;
    r.c = 1'b0;
    r.o = 1'b0;
    case (f)
      3'd0: r.y = a & b;
      3'd1: r.y = a | b;
      3'd2: begin
        s = ua + ub;
        ss = sa + sb;
        r.y = s[15:0];
        r.c = (s > 65535);
        r.o = (ss > 32767) || (ss < -32768);
      end
      3'd4: r.y = a ^ b;
      3'd5: r.y = ~(a | b);
      3'd6: begin
        s = ua - ub;
        ss = sa - sb;
        r.y = s[15:0];
        r.c = (ua < ub);
        r.o = (ss > 32767) || (ss < -32768);
      end
      3'd7: begin
        r.y = (sa < sb) ? 16'd1 : 16'd0;
        r.c = (ua < ub);
      end
      default: r.y = '0;
    endcase
    r.z = (r.y == 16'd0);
    return r;
  endfunction

  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Single requester op, full-speed consumer; checks grant, EXEC bubble and result
  task automatic run_single(input int r, input vec_t v, input string name);
    req_valid = '0;
    req_valid[r] = 1'b1;
    va[r] = v.a;
    vb[r] = v.b;
    vf[r] = v.f;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({name, "_grant"}, 32'(req_ready), 32'(4'b1 << r));
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk({name, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_id"}, 32'(rsp_id), 32'(r));
    chk({name, "_y"}, 32'(rsp_y), 32'(v.y));
    chk({name, "_flags"}, {29'd0, rsp_zero, rsp_carry, rsp_ovf}, {29'd0, v.z, v.c, v.o});
`ifdef ALU_ARB_ERR_EN
    chk({name, "_err"}, 32'(rsp_err), 32'(v.f == 3'b011));
`endif
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [14];
  res_t q [$];
  res_t e;

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc, rc, last_cyc, g, ptr, nresp;
    bit busy, found;
    logic [NREQ-1:0] accepted;

    for (int i = 0; i < NREQ; i++) begin
      va[i] = '0;
      vb[i] = '0;
      vf[i] = '0;
    end

    //            a         b         f     y        z     c     o
    tbl[0]  = '{16'h7FFF, 16'h0001, 3'd2, 16'h8000, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{16'h0005, 16'h0005, 3'd6, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{16'h0003, 16'h0005, 3'd7, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{16'hFFFF, 16'h0F0F, 3'd0, 16'h0F0F, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{16'h00F0, 16'h0F00, 3'd1, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'hAAAA, 16'hAAAA, 3'd4, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{16'h0000, 16'h0000, 3'd5, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{16'hFFFF, 16'h0001, 3'd2, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0001, 3'd6, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{16'h8000, 16'h0001, 3'd6, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{16'h8000, 16'h0001, 3'd7, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{16'hFFFF, 16'hFFFF, 3'd3, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{16'h0005, 16'h0003, 3'd7, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{16'h8000, 16'h8000, 3'd2, 16'h0000, 1'b1, 1'b1, 1'b1};

    // Reset state and idle with no requests
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_data", {rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_ovf}, 32'd0);
`ifdef ALU_ARB_ERR_EN
      chk("rst_err", 32'(rsp_err), 32'd0);
`endif
    end
    @(posedge clk);
    #1;

    // Vector table, requester rotates with index
    for (int i = 0; i < 14; i++) begin
      run_single(i % NREQ, tbl[i], $sformatf("vec%0d", i));
      $display("vec %0d req=%0d f=%0d a=%h b=%h y=%h", i, i % NREQ, tbl[i].f, tbl[i].a, tbl[i].b, rsp_y);
    end

    // All requesters continuously valid: strict rotation, 3-cycle spacing
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      va[i] = 16'h0005;
      vb[i] = 16'h0005;
      vf[i] = 3'd6;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    nacc = 0;
    rc = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("rr_rsp_id", 32'(rsp_id), 32'(rc % NREQ));
        chk("rr_rsp", {rsp_y, rsp_zero, rsp_carry}, {16'd0, 1'b1, 1'b0});
        rc++;
      end
      if (req_ready != '0) begin
        chk("rr_grant", 32'(req_ready), 32'(4'b1 << (nacc % NREQ)));
        if (nacc > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd3);
        $display("rr accept %0d ready=%b cycle=%0d", nacc, req_ready, cyc);
        last_cyc = cyc;
        nacc++;
        if (nacc == 5) break;
      end
    end
    chk("rr_grants", 32'(nacc), 32'd5);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Response stall on req2 SLT while req0 also waits
    req_valid = 4'b0101;
    va[2] = 16'h0003; vb[2] = 16'h0005; vf[2] = 3'd7;
    va[0] = 16'h0001; vb[0] = 16'h0002; vf[0] = 3'd2;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("stall_grant", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    chk("stall_exec_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_hold", {rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_ovf},
          {1'b1, 2'd2, 16'h0001, 1'b0, 1'b1, 1'b0});
      chk("stall_ready", 32'(req_ready), 32'd0);
      $display("stall cycle %0d valid=%b y=%h ready=%b", c, rsp_valid, rsp_y, req_ready);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_after_ready", 32'(req_ready), 32'h1);
    chk("stall_after_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("stall_next_rsp", {rsp_valid, rsp_id, rsp_y}, {1'b1, 2'd0, 16'h0003});
    @(posedge clk);
    #1;

    // Reset during EXEC discards the op and returns rr_ptr to 0
    run_single(2, tbl[4], "prep");
    req_valid = 4'b0010;
    va[1] = 16'hF0F0; vb[1] = 16'hFF00; vf[1] = 3'd0;
    @(negedge clk);
    chk("rexec_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 begin
      req_valid = '0;
      reset = 1'b1;
    end
    @(negedge clk);
    chk("rexec_valid0", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 begin
      reset = 1'b0;
      req_valid = 4'b1100;
      va[2] = 16'h0001; vb[2] = 16'h0001; vf[2] = 3'd2;
      va[3] = 16'h0009; vb[3] = 16'h0001; vf[3] = 3'd2;
    end
    @(negedge clk);
    chk("rexec_valid1", 32'(rsp_valid), 32'd0);
    chk("rexec_y", 32'(rsp_y), 32'd0);
    chk("rexec_grant_low", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("rexec_valid2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rexec_rsp", {rsp_valid, rsp_id, rsp_y}, {1'b1, 2'd2, 16'h0002});
    $display("reset-in-exec follow-up id=%0d y=%h", rsp_id, rsp_y);
    @(posedge clk);
    #1;

    // Random traffic against a transaction-level model
    do_reset();
    ptr = 0;
    busy = 0;
    nresp = 0;
    accepted = '0;
    q.delete();
    for (int cyc = 0; cyc < 520; cyc++) begin
      @(negedge clk);
      g = 0;
      found = 0;
      if (!busy) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!found && req_valid[(ptr + k) % NREQ]) begin
            found = 1;
            g = (ptr + k) % NREQ;
          end
        end
        chk("rnd_ready", 32'(req_ready), found ? 32'(4'b1 << g) : 32'd0);
        chk("rnd_idle_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rnd_busy_ready", 32'(req_ready), 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_id", 32'(rsp_id), 32'(e.id));
          chk("rnd_y", 32'(rsp_y), 32'(e.y));
          chk("rnd_flags", {29'd0, rsp_zero, rsp_carry, rsp_ovf}, {29'd0, e.z, e.c, e.o});
          $display("rnd rsp %0d id=%0d y=%h z=%b c=%b o=%b", nresp, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_ovf);
          ptr = (int'(e.id) + 1) % NREQ;
          nresp++;
        end
        busy = 0;
      end
      if (found) begin
        e = ref_alu(va[g], vb[g], vf[g]);
        e.id = 2'(g);
        q.push_back(e);
        busy = 1;
      end
      accepted = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (cyc < 500) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req_valid[i] || accepted[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              req_valid[i] = 1'b1;
              va[i] = pick_op();
              vb[i] = pick_op();
              vf[i] = 3'($urandom_range(0, 7));
            end else begin
              req_valid[i] = 1'b0;
            end
          end else if ($urandom_range(0, 9) == 0) begin
            req_valid[i] = 1'b0;
          end
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
    end
    chk("rnd_drain", 32'(q.size()), 32'd0);
    chk("rnd_enough", 32'(nresp >= 40), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
